// File: rtl/nec_ir_rx.sv
// NEC IR receiver: times marks/spaces of the demodulated input and decodes leader,
// 32 data bits, stop and repeat codes into registered addr/cmd and one-cycle pulses.
module nec_ir_rx #(
  parameter int CLK_PER_US = 50,
  parameter int TIMEOUT_US = 12000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       ir_n,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       valid,
  output logic       repeat_code,
  output logic       err,
  output logic       busy
);

  localparam int            PW      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_US - 1);
  localparam logic [13:0]   US_MAX  = 14'h3FFF;
  localparam logic [13:0]   TO_US   = 14'(TIMEOUT_US);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_MARK
  } state_t;

  state_t        state;
  logic          ir_s1, ir_s2, ir_prev;
  logic          fall, rise, any_edge;
  logic [PW-1:0] pre;
  logic [13:0]   us_cnt;
  logic [13:0]   d;
  logic          tick;
  logic          timeout;
  logic [5:0]    bit_cnt;
  logic [31:0]   sr;
  logic          have_frame;
  logic          in_lead, in_hdr, in_rep, in_short, in_long, cmp_ok;

  function automatic logic in_win(input logic [13:0] v, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Flops reset to idle level so leaving reset never looks like a mark start.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      ir_s1   <= 1'b1;
      ir_s2   <= 1'b1;
      ir_prev <= 1'b1;
    end else begin
      ir_s1   <= ir_n;
      ir_s2   <= ir_s1;
      ir_prev <= ir_s2;
    end
  end

  assign fall     = ir_prev & ~ir_s2;
  assign rise     = ~ir_prev & ir_s2;
  assign any_edge = fall | rise;

  assign tick = (pre == PRE_MAX);

  // d includes this cycle's increment, so a width of N us measures exactly N.
  always_comb begin
    d = us_cnt;
    if (tick && (us_cnt != US_MAX)) d = us_cnt + 14'd1;
  end

  always_ff @(posedge clk_50) begin
    if (reset || any_edge) begin
      pre    <= '0;
      us_cnt <= '0;
    end else begin
      pre    <= tick ? '0 : pre + 1'b1;
      us_cnt <= d;
    end
  end

  assign timeout  = (state != IDLE) && !any_edge && tick && (us_cnt == TO_US - 14'd1);
  assign in_lead  = in_win(d, 14'd8000, 14'd10000);
  assign in_hdr   = in_win(d, 14'd4000, 14'd5000);
  assign in_rep   = in_win(d, 14'd2000, 14'd2500);
  assign in_short = in_win(d, 14'd400, 14'd700);
  assign in_long  = in_win(d, 14'd1400, 14'd1900);
  assign cmp_ok   = ((sr[7:0] ^ sr[15:8]) == 8'hFF) && ((sr[23:16] ^ sr[31:24]) == 8'hFF);

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      sr          <= '0;
      have_frame  <= 1'b0;
      addr        <= '0;
      cmd         <= '0;
      valid       <= 1'b0;
      repeat_code <= 1'b0;
      err         <= 1'b0;
    end else begin
      valid       <= 1'b0;
      repeat_code <= 1'b0;
      err         <= 1'b0;
      if (timeout) begin
        err   <= 1'b1;
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              state <= LEAD_MARK;
              busy  <= 1'b1;
            end
          end
          LEAD_MARK: begin
            if (rise) begin
              if (in_lead) begin
                state <= LEAD_SPACE;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          LEAD_SPACE: begin
            if (fall) begin
              if (in_hdr) begin
                state   <= BIT_MARK;
                bit_cnt <= '0;
              end else if (in_rep) begin
                state <= REP_MARK;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          BIT_MARK: begin
            if (rise) begin
              if (in_short) begin
                state <= BIT_SPACE;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          BIT_SPACE: begin
            if (fall) begin
              if (in_short || in_long) begin
                // LSB first: after 32 shifts the first bit sits in sr[0].
                sr      <= {in_long, sr[31:1]};
                bit_cnt <= bit_cnt + 6'd1;
                state   <= (bit_cnt == 6'd31) ? STOP_MARK : BIT_MARK;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          STOP_MARK: begin
            if (rise) begin
              if (in_short && cmp_ok) begin
                addr       <= sr[7:0];
                cmd        <= sr[23:16];
                valid      <= 1'b1;
                have_frame <= 1'b1;
              end else begin
                err <= 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          REP_MARK: begin
            if (rise) begin
              if (!in_short) err <= 1'b1;
              else if (have_frame) repeat_code <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_rx.sv
// Randomized NEC frame bench: stimulus tasks push expected pulses into a scoreboard
// queue and a negedge monitor pops and compares each pulse the decoder emits.
module tb_nec_ir_rx;

  localparam int CPU = 1;
  localparam int GAP = 50;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic       ir_n = 1'b1;
  logic [7:0] addr, cmd;
  logic       valid, repeat_code, err, busy;

  nec_ir_rx #(.CLK_PER_US(CPU), .TIMEOUT_US(12000)) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .ir_n       (ir_n),
    .addr       (addr),
    .cmd        (cmd),
    .valid      (valid),
    .repeat_code(repeat_code),
    .err        (err),
    .busy       (busy)
  );

  always #10 clk_50 = ~clk_50;

  int unsigned cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  typedef enum logic [1:0] {EV_VALID, EV_REPEAT, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned at;
    logic [7:0]  a;
    logic [7:0]  c;
  } ev_t;
  typedef struct {
    logic        pass;
    string       name;
    int unsigned act;
    int unsigned exp;
  } chk_t;

  ev_t  exp_q[$];
  chk_t chk_q[$];
  int   tests = 0;
  int   failed = 0;

  // Reference model state: what a correct receiver remembers between frames.
  logic       m_have = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_cmd = 8'h00;

  function automatic logic in_win(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // A pulse is due in the cycle after the third edge following the input change.
  function automatic void expect_ev(input ev_kind_t k, input int unsigned t_change);
    ev_t e;
    e.kind = k;
    e.at   = t_change + 3;
    e.a    = m_addr;
    e.c    = m_cmd;
    exp_q.push_back(e);
  endfunction

  function automatic void check(input logic pass, input string name,
                                input int unsigned act, input int unsigned exp);
    chk_t c;
    c.pass = pass;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endfunction

  always @(negedge clk_50) begin : monitor
    chk_t       c;
    ev_t        e;
    logic [2:0] got, want;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      tests++;
      if (!c.pass) begin
        failed++;
        $display("FAIL %s: got %0d, required %0d", c.name, c.act, c.exp);
      end
    end
    got = {valid, repeat_code, err};
    if (got != 3'b000) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_pulse: got valid/repeat/err=%b at cycle %0d, required none",
                 got, cyc);
      end else begin
        e = exp_q.pop_front();
        want = (e.kind == EV_VALID) ? 3'b100 : (e.kind == EV_REPEAT) ? 3'b010 : 3'b001;
        if (got != want || cyc != e.at || addr != e.a || cmd != e.c || busy) begin
          failed++;
          $display("FAIL pulse: got vre=%b cyc=%0d addr=%h cmd=%h busy=%b, required vre=%b cyc=%0d addr=%h cmd=%h busy=0",
                   got, cyc, addr, cmd, busy, want, e.at, e.a, e.c);
        end
      end
    end
  end

  task automatic hold(input logic lvl, input int us, output int unsigned t_end);
    ir_n = lvl;
    repeat (us * CPU) @(posedge clk_50);
    #1;
    t_end = cyc;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk_50);
    #1;
    reset = 1'b0;
    m_have = 1'b0;
    m_addr = 8'h00;
    m_cmd  = 8'h00;
    check({addr, cmd, valid, repeat_code, err, busy} == 20'd0, "reset_outputs",
          32'({busy, err, repeat_code, valid, cmd, addr}), 0);
  endtask

  task automatic drain(input string name);
    check(exp_q.size() == 0, name, exp_q.size(), 0);
  endtask

  task automatic send_repeat(input int lead, input int sp, input int mk);
    int unsigned te;
    hold(1'b0, lead, te);
    if (!in_win(lead, 8000, 10000)) begin
      expect_ev(EV_ERR, te);
      hold(1'b1, GAP, te);
      return;
    end
    hold(1'b1, sp, te);
    hold(1'b0, mk, te);
    if (!in_win(mk, 400, 700)) expect_ev(EV_ERR, te);
    else if (m_have) expect_ev(EV_REPEAT, te);
    hold(1'b1, GAP, te);
  endtask

  // rst_at >= 0 pulses reset just before data bit rst_at; the leftover bit marks
  // then reach the decoder as too-short leaders.
  task automatic send_frame(input logic [31:0] w, input logic nom, input int rst_at);
    int unsigned te;
    int          mk, sp;
    logic        dead;
    dead = 1'b0;
    hold(1'b0, nom ? 9000 : int'($urandom_range(8000, 10000)), te);
    hold(1'b1, nom ? 4500 : int'($urandom_range(4000, 5000)), te);
    check(busy == 1'b1, "busy_in_frame", 32'(busy), 1);
    for (int i = 0; i < 32; i++) begin
      if (i == rst_at) begin
        pulse_reset();
        dead = 1'b1;
      end
      mk = nom ? 560 : int'($urandom_range(400, 700));
      if (w[i]) sp = nom ? 1690 : int'($urandom_range(1400, 1900));
      else      sp = nom ? 560 : int'($urandom_range(400, 700));
      hold(1'b0, mk, te);
      if (dead && !in_win(mk, 8000, 10000)) expect_ev(EV_ERR, te);
      hold(1'b1, sp, te);
    end
    mk = nom ? 560 : int'($urandom_range(400, 700));
    hold(1'b0, mk, te);
    if (dead) begin
      if (!in_win(mk, 8000, 10000)) expect_ev(EV_ERR, te);
    end else if (((w[7:0] ^ w[15:8]) == 8'hFF) && ((w[23:16] ^ w[31:24]) == 8'hFF)) begin
      m_addr = w[7:0];
      m_cmd  = w[23:16];
      m_have = 1'b1;
      expect_ev(EV_VALID, te);
    end else begin
      expect_ev(EV_ERR, te);
    end
    hold(1'b1, GAP, te);
  endtask

  function automatic logic [31:0] mkw(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  initial begin
    int unsigned te;
    int          leads[4];
    leads = '{7999, 8000, 10000, 10001};

    repeat (3) @(posedge clk_50);
    #1;
    reset = 1'b0;
    @(posedge clk_50);
    #1;
    check({addr, cmd, valid, repeat_code, err, busy} == 20'd0, "reset_state",
          32'({busy, err, repeat_code, valid, cmd, addr}), 0);

    send_repeat(9000, 2250, 560);
    drain("repeat_before_any_frame");

    send_frame(mkw(8'h04, 8'h08), 1'b1, -1);
    drain("nominal_frame");

    send_repeat(9000, 2250, 560);
    drain("repeat_after_frame");

    foreach (leads[i]) begin
      send_repeat(leads[i], int'($urandom_range(2000, 2500)), int'($urandom_range(400, 700)));
      drain("leader_boundary");
    end

    // 1000 us bit space lies between the 0 and 1 windows.
    hold(1'b0, 9000, te);
    hold(1'b1, 4500, te);
    hold(1'b0, 560, te);
    hold(1'b1, 1000, te);
    if (!(in_win(1000, 400, 700) || in_win(1000, 1400, 1900))) expect_ev(EV_ERR, te);
    hold(1'b0, 560, te);
    hold(1'b1, GAP, te);
    drain("bit_space_1000");

    te = cyc;
    expect_ev(EV_ERR, te + 12000);
    hold(1'b0, 15000, te);
    hold(1'b1, GAP, te);
    drain("timeout");
    send_frame(mkw(8'($urandom), 8'($urandom)), 1'b0, -1);
    drain("frame_after_timeout");

    send_frame({8'hF6, 8'h08, 8'hFB, 8'h04}, 1'b1, -1);
    drain("bad_complement");

    send_frame(mkw(8'($urandom), 8'($urandom)), 1'b0, 16);
    drain("reset_mid_frame");
    send_repeat(9000, 2250, 560);
    drain("repeat_after_reset");
    send_frame(mkw(8'($urandom), 8'($urandom)), 1'b0, -1);
    drain("frame_after_reset");

    repeat (3) @(negedge clk_50);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
